alu_config_loader: RTL

//   Initiator side of the SimpleALU configuration port. Accepts config write requests

---
 rtl/alu_config_loader.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/alu_config_loader.sv
`default_nettype none
// ============================================================================
//  Module      : alu_config_loader
//  Description : Initiator side of the SimpleALU configuration port. Accepts
//                config writes over valid/ready, drives the shared config
//                bus plus per-tile enables, keeps a shadow copy of every
//                tile's opcode for readback and holds a settle window after
//                each write.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_config_loader #(
  parameter int N_TILES       = 4,
  parameter int CFG_WIDTH     = 2,
  parameter int SETTLE_CYCLES = 2,
  localparam int AW           = (N_TILES > 1) ? $clog2(N_TILES) : 1
) (
  input  logic                 CLK,
  input  logic                 ASYNCRESETN,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [AW-1:0]        req_addr,
  input  logic                 req_bcast,
  input  logic [CFG_WIDTH-1:0] req_data,
  output logic [CFG_WIDTH-1:0] config_data,
  output logic [N_TILES-1:0]   config_en,
  output logic                 done,
  output logic                 err,
  input  logic [AW-1:0]        rd_addr,
  output logic [CFG_WIDTH-1:0] rd_data
);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_WRITE  = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  // One extra bit so N_TILES itself is representable for range checks.
  localparam logic [AW:0] c_n_tiles = (AW + 1)'(N_TILES);
  localparam logic [7:0]  c_settle  = 8'(SETTLE_CYCLES);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CFG_WIDTH-1:0]  r_cfg_data;
  logic [CFG_WIDTH-1:0]  w_cfg_data_nxt;
  logic [N_TILES-1:0]    r_cfg_en;
  logic [N_TILES-1:0]    w_cfg_en_nxt;
  logic                  r_done;
  logic                  w_done_nxt;
  logic                  r_err;
  logic                  w_err_nxt;
  logic [7:0]            r_cnt;
  logic [7:0]            w_cnt_nxt;
  // Set while the settle window belongs to the post-reset sweep, which
  // must not produce a done pulse.
  logic                  r_init_settle;
  logic                  w_init_settle_nxt;
  logic [CFG_WIDTH-1:0]  r_shadow [N_TILES];
  logic [CFG_WIDTH-1:0]  r_rd_data;

  logic                  w_accept;
  logic                  w_addr_ok;
  logic                  w_rd_ok;
  logic [N_TILES-1:0]    w_sel;

  assign req_ready   = (r_state == ST_IDLE);
  assign config_data = r_cfg_data;
  assign config_en   = r_cfg_en;
  assign done        = r_done;
  assign err         = r_err;
  assign rd_data     = r_rd_data;

  assign w_accept  = req_valid & req_ready;
  assign w_addr_ok = req_bcast | ({1'b0, req_addr} < c_n_tiles);
  assign w_rd_ok   = ({1'b0, rd_addr} < c_n_tiles);

  // Target decode: one-hot tile select, or every tile on broadcast.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < N_TILES; i++) begin
      w_sel[i] = req_bcast | (req_addr == AW'(i));
    end
  end

  // Next-state and next-output logic for the loader FSM.
  always_comb begin
    w_state_nxt       = r_state;
    w_cfg_data_nxt    = r_cfg_data;
    w_cfg_en_nxt      = '0;
    w_done_nxt        = 1'b0;
    w_err_nxt         = 1'b0;
    w_cnt_nxt         = r_cnt;
    w_init_settle_nxt = r_init_settle;
    case (r_state)
      ST_INIT: begin
        // Sweep every tile to opcode 0; the sweep cycle itself plus the
        // full settle window are spent in SETTLE, hence the unreduced count.
        w_cfg_en_nxt      = '1;
        w_cfg_data_nxt    = '0;
        w_cnt_nxt         = c_settle;
        w_init_settle_nxt = 1'b1;
        w_state_nxt       = ST_SETTLE;
      end
      ST_IDLE: begin
        if (w_accept) begin
          if (!w_addr_ok) begin
            w_err_nxt = 1'b1;
          end else begin
            w_cfg_data_nxt = req_data;
            w_cfg_en_nxt   = w_sel;
            w_done_nxt     = (SETTLE_CYCLES == 0);
            w_state_nxt    = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        w_init_settle_nxt = 1'b0;
        if (SETTLE_CYCLES == 0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt   = c_settle - 8'd1;
          w_done_nxt  = (SETTLE_CYCLES == 1);
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt  = r_cnt - 8'd1;
          w_done_nxt = (r_cnt == 8'd1) & ~r_init_settle;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_state       <= ST_INIT;
      r_cfg_data    <= '0;
      r_cfg_en      <= '0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_cnt         <= 8'd0;
      r_init_settle <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cfg_data    <= w_cfg_data_nxt;
      r_cfg_en      <= w_cfg_en_nxt;
      r_done        <= w_done_nxt;
      r_err         <= w_err_nxt;
      r_cnt         <= w_cnt_nxt;
      r_init_settle <= w_init_settle_nxt;
    end
  end

  // Shadow copy updates on the same edge the enabled tiles capture.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      for (int i = 0; i < N_TILES; i++) begin
        r_shadow[i] <= '0;
      end
    end else if (r_state == ST_WRITE) begin
      for (int i = 0; i < N_TILES; i++) begin
        if (r_cfg_en[i]) begin
          r_shadow[i] <= r_cfg_data;
        end
      end
    end
  end

  // Registered readback; out-of-range addresses read as zero.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= w_rd_ok ? r_shadow[rd_addr] : '0;
    end
  end

endmodule
`default_nettype wire
